// File: rtl/floo_vc_credit_scheduler.sv
// Multi-VC link scheduler: round-robins data flits and credit returns onto one serial link.
// Define FLOO_VC_SCHED_FORCE_CREDIT_EN to enable credit-only packets once returns pile up.
module floo_vc_credit_scheduler #(
    parameter int unsigned NumVc           = 2,
    parameter int unsigned DataW           = 32,
    parameter int unsigned NumCredits      = 6,
    parameter int unsigned ForceSendThresh = NumCredits - 4,
    localparam int unsigned VcIdxW         = (NumVc > 1) ? $clog2(NumVc) : 1,
    localparam int unsigned CreditW        = $clog2(NumCredits + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumVc-1:0]           vc_valid_i,
    output logic [NumVc-1:0]           vc_ready_o,
    input  logic [NumVc*DataW-1:0]     vc_data_i,
    input  logic [NumVc-1:0]           free_i,
    input  logic                       cred_rx_valid_i,
    input  logic [VcIdxW-1:0]          cred_rx_vc_i,
    input  logic [CreditW-1:0]         cred_rx_num_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [VcIdxW-1:0]          out_vc_o,
    output logic [DataW-1:0]           out_data_o,
    output logic                       out_data_valid_o,
    output logic [CreditW-1:0]         out_credits_o,
    output logic [NumVc*CreditW-1:0]   tx_credits_o
);

    if (NumVc < 2 || ForceSendThresh < 1 || ForceSendThresh > NumCredits) begin : g_param_err
        $error("floo_vc_credit_scheduler: invalid NumVc/ForceSendThresh");
    end

    logic [NumVc-1:0][DataW-1:0]   vc_data;
    logic [NumVc-1:0][CreditW-1:0] tx_cnt_q, tx_cnt_d;
    logic [NumVc-1:0][CreditW-1:0] ret_cnt_q, ret_cnt_d;
    logic [NumVc-1:0]              data_elig, cred_elig, elig;
    logic [VcIdxW-1:0]             ptr_q, ptr_d, win_idx, cand;
    logic [VcIdxW:0]               cand_sum;
    logic                          win_found, load_en, load, win_is_data;
    logic [CreditW-1:0]            inc;
    logic                          dec;
    logic [CreditW:0]              tx_sum;

    logic                          out_valid_q, out_data_valid_q;
    logic [VcIdxW-1:0]             out_vc_q;
    logic [DataW-1:0]              out_data_q;
    logic [CreditW-1:0]            out_credits_q;

    assign vc_data      = vc_data_i;
    assign tx_credits_o = tx_cnt_q;

    // Eligibility uses registered counters only, so same-cycle credits never unblock a VC.
    always_comb begin
        data_elig = '0;
        cred_elig = '0;
        for (int k = 0; k < NumVc; k++) begin
            data_elig[k] = vc_valid_i[k] && (tx_cnt_q[k] != '0);
        end
`ifdef FLOO_VC_SCHED_FORCE_CREDIT_EN
        for (int k = 0; k < NumVc; k++) begin
            cred_elig[k] = (ret_cnt_q[k] >= CreditW'(ForceSendThresh)) && !data_elig[k];
        end
`endif
        elig = data_elig | cred_elig;
    end

    // Round-robin scan starting at the pointer; data and credit-only share the ring.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = 0; i < NumVc; i++) begin
            cand_sum = {1'b0, ptr_q} + (VcIdxW+1)'(i);
            if (cand_sum >= (VcIdxW+1)'(NumVc)) begin
                cand_sum = cand_sum - (VcIdxW+1)'(NumVc);
            end
            cand = cand_sum[VcIdxW-1:0];
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign load_en     = !out_valid_q || out_ready_i;
    assign load        = load_en && win_found;
    assign win_is_data = data_elig[win_idx];

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = (win_idx == VcIdxW'(NumVc - 1)) ? '0 : win_idx + VcIdxW'(1);
        end
    end

    always_comb begin
        vc_ready_o = '0;
        if (rst_ni && load && win_is_data) begin
            vc_ready_o[win_idx] = 1'b1;
        end
    end

    always_comb begin
        tx_cnt_d  = tx_cnt_q;
        ret_cnt_d = ret_cnt_q;
        inc       = '0;
        dec       = 1'b0;
        tx_sum    = '0;
        for (int k = 0; k < NumVc; k++) begin
            inc    = (cred_rx_valid_i && cred_rx_vc_i == VcIdxW'(k)) ? cred_rx_num_i : '0;
            dec    = load && win_is_data && (win_idx == VcIdxW'(k));
            tx_sum = {1'b0, tx_cnt_q[k]} + {1'b0, inc} - {{CreditW{1'b0}}, dec};
            tx_cnt_d[k] = (tx_sum > (CreditW+1)'(NumCredits)) ? CreditW'(NumCredits)
                                                               : tx_sum[CreditW-1:0];
            // A loaded packet carries the pre-load count; a concurrent free starts the next batch.
            if (load && (win_idx == VcIdxW'(k))) begin
                ret_cnt_d[k] = {{(CreditW-1){1'b0}}, free_i[k]};
            end else if (free_i[k] && (ret_cnt_q[k] != CreditW'(NumCredits))) begin
                ret_cnt_d[k] = ret_cnt_q[k] + CreditW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_cnt_q         <= {NumVc{CreditW'(NumCredits)}};
            ret_cnt_q        <= '0;
            ptr_q            <= '0;
            out_valid_q      <= 1'b0;
            out_vc_q         <= '0;
            out_data_q       <= '0;
            out_data_valid_q <= 1'b0;
            out_credits_q    <= '0;
        end else begin
            tx_cnt_q  <= tx_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            ptr_q     <= ptr_d;
            if (load_en) begin
                out_valid_q <= load;
                if (load) begin
                    out_vc_q         <= win_idx;
                    out_data_q       <= win_is_data ? vc_data[win_idx] : '0;
                    out_data_valid_q <= win_is_data;
                    out_credits_q    <= ret_cnt_q[win_idx];
                end
            end
        end
    end

    assign out_valid_o      = out_valid_q;
    assign out_vc_o         = out_vc_q;
    assign out_data_o       = out_data_q;
    assign out_data_valid_o = out_data_valid_q;
    assign out_credits_o    = out_credits_q;

endmodule

// File: tb/tb_floo_vc_credit_scheduler.sv
// Scoreboard bench for floo_vc_credit_scheduler; reference model applies the scheduling rules
// with integer counters. Honours FLOO_VC_SCHED_FORCE_CREDIT_EN when defined.
module tb_floo_vc_credit_scheduler;

    localparam int NumVc      = 2;
    localparam int DataW      = 32;
    localparam int NumCredits = 6;
    localparam int Thresh     = NumCredits - 4;
    localparam int VcIdxW     = 1;
    localparam int CreditW    = 3;
    localparam int PW         = VcIdxW + 1 + CreditW + DataW;
`ifdef FLOO_VC_SCHED_FORCE_CREDIT_EN
    localparam bit ForceEn = 1'b1;
`else
    localparam bit ForceEn = 1'b0;
`endif

    logic                     clk;
    logic                     rst_ni;
    logic [NumVc-1:0]         vc_valid_i, vc_ready_o, free_i;
    logic [NumVc*DataW-1:0]   vc_data_i;
    logic                     cred_rx_valid_i;
    logic [VcIdxW-1:0]        cred_rx_vc_i;
    logic [CreditW-1:0]       cred_rx_num_i;
    logic                     out_valid_o, out_ready_i, out_data_valid_o;
    logic [VcIdxW-1:0]        out_vc_o;
    logic [DataW-1:0]         out_data_o;
    logic [CreditW-1:0]       out_credits_o;
    logic [NumVc*CreditW-1:0] tx_credits_o;

    floo_vc_credit_scheduler #(
        .NumVc(NumVc), .DataW(DataW), .NumCredits(NumCredits), .ForceSendThresh(Thresh)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .vc_valid_i(vc_valid_i), .vc_ready_o(vc_ready_o), .vc_data_i(vc_data_i),
        .free_i(free_i),
        .cred_rx_valid_i(cred_rx_valid_i), .cred_rx_vc_i(cred_rx_vc_i),
        .cred_rx_num_i(cred_rx_num_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_vc_o(out_vc_o),
        .out_data_o(out_data_o), .out_data_valid_o(out_data_valid_o),
        .out_credits_o(out_credits_o), .tx_credits_o(tx_credits_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [PW-1:0] exp_q[$];
    int vc_log[$];
    int pkt_cnt = 0;
    int last_vc, last_dv, last_cred;
    logic [NumVc-1:0] last_rdy;

    // Reference state
    int m_tx[NumVc];
    int m_ret[NumVc];
    int m_ptr;
    bit m_full;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: a transfer completes at a rising edge where valid and ready are both high.
    always @(posedge clk) begin
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pkt: got vc=%0d dv=%0b cred=%0d expected none",
                         out_vc_o, out_data_valid_o, out_credits_o);
            end else begin
                check("pkt", 64'({out_vc_o, out_data_valid_o, out_credits_o, out_data_o}),
                      64'(exp_q.pop_front()));
            end
            pkt_cnt++;
            last_vc   = int'(out_vc_o);
            last_dv   = int'(out_data_valid_o);
            last_cred = int'(out_credits_o);
            vc_log.push_back(int'(out_vc_o));
        end
    end

    task automatic model_eval();
        bit de[NumVc];
        bit ce[NumVc];
        bit load_en;
        int win;
        int c;
        int t;
        logic [NumVc-1:0] exp_rdy;
        logic [DataW-1:0] pay;
        for (int k = 0; k < NumVc; k++)
            check("tx_cnt", 64'(tx_credits_o[k*CreditW +: CreditW]), 64'(m_tx[k]));
        load_en = !m_full || out_ready_i;
        win = -1;
        for (int k = 0; k < NumVc; k++) begin
            de[k] = vc_valid_i[k] && (m_tx[k] > 0);
            ce[k] = ForceEn && (m_ret[k] >= Thresh) && !de[k];
        end
        for (int i = 0; i < NumVc; i++) begin
            c = (m_ptr + i) % NumVc;
            if (win < 0 && (de[c] || ce[c])) win = c;
        end
        exp_rdy = '0;
        if (load_en && win >= 0) begin
            pay = de[win] ? vc_data_i[win*DataW +: DataW] : '0;
            if (de[win]) exp_rdy[win] = 1'b1;
            exp_q.push_back({VcIdxW'(win), de[win], CreditW'(m_ret[win]), pay});
            m_full = 1'b1;
            m_ptr  = (win + 1) % NumVc;
        end else if (load_en) begin
            m_full = 1'b0;
        end
        last_rdy = vc_ready_o;
        check("vc_ready", 64'(vc_ready_o), 64'(exp_rdy));
        for (int k = 0; k < NumVc; k++) begin
            t = m_tx[k];
            if (cred_rx_valid_i && int'(cred_rx_vc_i) == k) t += int'(cred_rx_num_i);
            if (exp_rdy[k]) t -= 1;
            m_tx[k] = (t > NumCredits) ? NumCredits : t;
            if (load_en && win == k) m_ret[k] = int'(free_i[k]);
            else if (free_i[k] && m_ret[k] < NumCredits) m_ret[k] += 1;
        end
    endtask

    // Driver: called at a falling edge, returns at the next falling edge.
    task automatic step(input logic [NumVc-1:0] v, input logic [NumVc-1:0] f, input bit crv,
                        input int crvc, input int crn, input bit rdy);
        vc_valid_i = v;
        for (int k = 0; k < NumVc; k++) vc_data_i[k*DataW +: DataW] = $urandom();
        free_i          = f;
        cred_rx_valid_i = crv;
        cred_rx_vc_i    = VcIdxW'(crvc);
        cred_rx_num_i   = CreditW'(crn);
        out_ready_i     = rdy;
        #1;
        model_eval();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, '0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        vc_valid_i = '1;
        free_i = '0;
        cred_rx_valid_i = 1'b0;
        cred_rx_vc_i = '0;
        cred_rx_num_i = '0;
        out_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_vc_ready", 64'(vc_ready_o), 64'(0));
        check("rst_out_valid", 64'(out_valid_o), 64'(0));
        check("rst_out_fields", 64'({out_vc_o, out_data_o, out_data_valid_o, out_credits_o}), 64'(0));
        for (int k = 0; k < NumVc; k++)
            check("rst_tx_cnt", 64'(tx_credits_o[k*CreditW +: CreditW]), 64'(NumCredits));
        for (int k = 0; k < NumVc; k++) begin
            m_tx[k]  = NumCredits;
            m_ret[k] = 0;
        end
        m_ptr = 0;
        m_full = 1'b0;
        exp_q.delete();
        vc_log.delete();
        last_vc = 0; last_dv = 1; last_cred = 7;
        vc_valid_i = '0;
        rst_ni = 1'b1;
    endtask

    logic [PW+1:0] snap;
    int base;

    initial begin
        rst_ni = 1'b0;
        vc_valid_i = '0; vc_data_i = '0; free_i = '0;
        cred_rx_valid_i = 1'b0; cred_rx_vc_i = '0; cred_rx_num_i = '0; out_ready_i = 1'b0;
        @(negedge clk);
        do_reset();

        // Credit exhaustion on VC0
        base = pkt_cnt;
        repeat (7) step(2'b01, '0, 1'b0, 0, 0, 1'b1);
        idle(3);
        check("exhaust_pkts", 64'(pkt_cnt - base), 64'(6));
        check("exhaust_tx0", 64'(tx_credits_o[0 +: CreditW]), 64'(0));

        // Alternation
        do_reset();
        repeat (8) step(2'b11, '0, 1'b0, 0, 0, 1'b1);
        idle(3);
        check("alt_count", 64'(vc_log.size()), 64'(8));
        for (int i = 0; i < vc_log.size() && i < 8; i++) check("alt_vc", 64'(vc_log[i]), 64'(i % 2));

        // Same-cycle credits do not unblock
        do_reset();
        repeat (6) step(2'b10, '0, 1'b0, 0, 0, 1'b1);
        idle(2);
        check("unblock_tx1_zero", 64'(tx_credits_o[CreditW +: CreditW]), 64'(0));
        step(2'b10, '0, 1'b1, 1, 3, 1'b1);
        check("unblock_no_grant", 64'(last_rdy[1]), 64'(0));
        check("unblock_tx1", 64'(tx_credits_o[CreditW +: CreditW]), 64'(3));
        step(2'b10, '0, 1'b0, 0, 0, 1'b1);
        check("unblock_grant", 64'(last_rdy[1]), 64'(1));
        idle(2);

        // Forced credit-only packet
        do_reset();
        base = pkt_cnt;
        step('0, 2'b01, 1'b0, 0, 0, 1'b1);
        step('0, 2'b01, 1'b0, 0, 0, 1'b1);
        idle(4);
        check("force_pkts", 64'(pkt_cnt - base), 64'(ForceEn ? 1 : 0));
        check("force_dv", 64'(last_dv), 64'(ForceEn ? 0 : 1));
        check("force_cred", 64'(last_cred), 64'(ForceEn ? 2 : 7));

        // Backpressure hold, then reset with a packet held
        do_reset();
        step(2'b01, '0, 1'b0, 0, 0, 1'b0);
        check("hold_valid", 64'(out_valid_o), 64'(1));
        snap = {out_valid_o, out_vc_o, out_data_o, out_data_valid_o, out_credits_o};
        repeat (5) begin
            step(2'b01, '0, 1'b0, 0, 0, 1'b0);
            check("hold_out", 64'({out_valid_o, out_vc_o, out_data_o, out_data_valid_o, out_credits_o}),
                  64'(snap));
            check("hold_no_ready", 64'(last_rdy), 64'(0));
        end
        do_reset();

        // Concurrent free on load
        step(2'b01, '0, 1'b0, 0, 0, 1'b0);
        repeat (3) step('0, 2'b10, 1'b0, 0, 0, 1'b0);
        step(2'b10, 2'b10, 1'b0, 0, 0, 1'b1);
        check("free_load_cred", 64'(out_credits_o), 64'(3));
        step(2'b10, '0, 1'b0, 0, 0, 1'b1);
        check("free_load_after", 64'(out_credits_o), 64'(1));
        idle(3);

        // Randomized traffic
        do_reset();
        repeat (400) begin
            step(NumVc'($urandom_range(0, 3)),
                 NumVc'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, NumVc - 1),
                 $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
        end
        idle(10);
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
